sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Sits between the ARM pipeline MEM stage and the external SRAM model.
- Turns single-cycle 32-bit word read/write requests from the MEM stage into timed SRAM bus cycles on SRAM_WE_N, SRAM_ADDR and SRAM_DQ.
- Drives ready low to freeze the pipeline while an access is in flight, then returns read data from the 64-bit SRAM data bus.

Parameters:
- WAIT_CYCLES, 5: clock cycles the SRAM bus is held per access. Must cover the SRAM 30 ns read delay plus margin. Legal range 2..15.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- DEPTH_WORDS, 512: number of 32-bit SRAM words reachable.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  MEM-stage write request.
- rd_en  in  1  MEM-stage read request.
- address  in  32  byte address of the request.
- writeData  in  32  data to write.
- readData  out  32  selected read word.
- readData64  out  64  full SRAM line from the last read.
- ready  out  1  0 = freeze pipeline.
- addr_err  out  1  last request was rejected.
- SRAM_WE_N  out  1  SRAM write strobe, active low.
- SRAM_ADDR  out  17  SRAM word address.
- SRAM_DQ  inout  64  SRAM data bus.

Behaviour:
- Reset: clk and rst as above; reset is synchronous and active-high. While rst is high at a posedge:
  - state becomes IDLE;
  - SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ released (all z);
  - readData=0, readData64=0, addr_err=0, counter=0.
  - ready reads 1 in IDLE with no request.
  - Reset during an access aborts it with no further bus activity. A write already strobed is not undone.
- Address translation:
  - waddr = (address - BASE_ADDR) >> 2, truncated to 17 bits.
  - The request is illegal if any of these hold: address < BASE_ADDR; address >= BASE_ADDR + 4*DEPTH_WORDS; address[1:0] != 0.
- Request priority: if wr_en and rd_en are both high, the write is served and the read is ignored.
- States:
  - IDLE:
    - ready = ~(wr_en | rd_en), combinational.
    - On a legal request: latch waddr, writeData and the operation; counter=0; go to ACCESS.
    - On an illegal request: go to DONE with err_pending set.
  - ACCESS:
    - ready=0. SRAM_ADDR = latched waddr. Counter increments each cycle.
    - Write: SRAM_WE_N=0 in the first ACCESS cycle only, 1 in all later cycles. SRAM_DQ[31:0] = latched writeData and SRAM_DQ[63:32] = 0 for all ACCESS cycles.
    - Read: SRAM_WE_N=1 and SRAM_DQ is z.
    - When counter == WAIT_CYCLES-1 on a read: capture readData64 <= SRAM_DQ; readData <= waddr[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0].
    - Go to DONE after WAIT_CYCLES cycles.
  - DONE:
    - ready=1 for exactly this cycle. SRAM_WE_N=1, SRAM_DQ z.
    - addr_err=1 if err_pending, else 0. addr_err then holds until the next request is accepted.
    - Always returns to IDLE. A request still asserted in DONE is not re-accepted; it is accepted in the following IDLE cycle as a new request.
- Latency:
  - Legal access accepted in cycle T: ready is low for T .. T+WAIT_CYCLES and high at T+WAIT_CYCLES+1 (DONE).
  - Illegal access: ready low in T only, high in T+1.
- Hold rules:
  - readData and readData64 hold their values until the next completed read. Writes and errors do not change them.
  - SRAM_ADDR holds its last value in IDLE and DONE.
- Request inputs are sampled only in IDLE. Changes to address or writeData during ACCESS have no effect.
- The controller never drives SRAM_DQ while SRAM_WE_N=1 and it is in a read or in IDLE, so there is no bus contention with the SRAM model.

Test Plan:
- Reset check: assert rst for 2 cycles mid-write (ACCESS, counter=2) -> next cycle IDLE, SRAM_WE_N=1, SRAM_DQ=z, ready=1, readData=0, addr_err=0.
- Write then read, low word: wr_en, address=1024, writeData=0xDEADBEEF -> SRAM_ADDR=0, SRAM_WE_N low for 1 cycle, ready low 6 cycles then high 1 cycle. Then rd_en, address=1024 -> readData=0xDEADBEEF in DONE, readData64[31:0]=0xDEADBEEF.
- Odd-word read: write 0x12345678 at 1028, then read 1028 -> SRAM_ADDR=1, readData=0x12345678 (taken from DQ[63:32]), readData64[63:32]=0x12345678.
- Illegal addresses: rd_en at 1020, then 1026, then 1024+2048 -> for each, no SRAM_WE_N pulse, SRAM_DQ stays z, ready low 1 cycle, addr_err=1 in DONE, readData unchanged.
- Simultaneous wr_en=rd_en=1: address=1032, writeData=0xA5A5A5A5 -> write performed; a subsequent read of 1032 returns 0xA5A5A5A5.
- Back-to-back held request: rd_en held high across DONE -> a second full access starts in the next IDLE cycle. Total ready pattern: 6 low, 1 high, 6 low, 1 high.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges single-cycle MEM-stage word requests onto a timed 64-bit SRAM bus,
// stalling the pipeline (ready=0) for the whole bus cycle.
module sram_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic [63:0] readData64,
    output logic        ready,
    output logic        addr_err,
    output logic        SRAM_WE_N,
    output logic [16:0] SRAM_ADDR,
    inout  tri   [63:0] SRAM_DQ
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] BASE       = 32'(BASE_ADDR);
    localparam logic [31:0] LIMIT      = 32'(BASE_ADDR + 4 * DEPTH_WORDS);
    localparam logic [3:0]  LAST_COUNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic        op_write;
    logic [31:0] wdata_q;
    logic [16:0] sram_addr_q;
    logic        request;
    logic        legal;
    logic        last_cycle;
    logic        dq_en;
    logic [16:0] waddr;

    assign request    = wr_en | rd_en;
    assign legal      = (address >= BASE) && (address < LIMIT) && (address[1:0] == 2'b00);
    assign waddr      = 17'((address - BASE) >> 2);
    assign last_cycle = (counter == LAST_COUNT);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = ~request;
                if (request) begin
                    state_next = legal ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write data stays on the bus for the whole access so the SRAM sees
    // stable data around the single-cycle strobe.
    assign dq_en     = (state == ACCESS) && op_write;
    assign SRAM_WE_N = ~(dq_en && (counter == 4'd0));
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DQ   = dq_en ? {32'h0, wdata_q} : {64{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= 4'd0;
            op_write    <= 1'b0;
            wdata_q     <= 32'h0;
            sram_addr_q <= 17'h0;
            readData    <= 32'h0;
            readData64  <= 64'h0;
            addr_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_err <= ~legal;
                        if (legal) begin
                            sram_addr_q <= waddr;
                            wdata_q     <= writeData;
                            op_write    <= wr_en;
                            counter     <= 4'd0;
                        end
                    end
                end
                ACCESS: begin
                    counter <= counter + 4'd1;
                    // The SRAM line holds an even/odd word pair; address bit 0 picks the half.
                    if (last_cycle && !op_write) begin
                        readData64 <= SRAM_DQ;
                        readData   <= sram_addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, reset/back-to-back sequences,
// and randomized traffic checked against a word-array reference model.
module tb_sram_controller;

    localparam int WAIT  = 5;
    localparam int BASE  = 1024;
    localparam int DEPTH = 512;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [63:0] readData64;
    logic        ready;
    logic        addr_err;
    logic        sram_we_n;
    logic [16:0] sram_addr;
    tri1  [63:0] sram_dq;

    sram_controller #(
        .WAIT_CYCLES(WAIT),
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .readData64(readData64),
        .ready     (ready),
        .addr_err  (addr_err),
        .SRAM_WE_N (sram_we_n),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- external SRAM model ----------------
    // Returns the even/odd word pair as one 64-bit line; drives the bus only
    // in the final access cycle to mimic the SRAM read delay.
    logic [31:0] sram_mem [0:DEPTH-1];
    logic        sram_oe;
    logic [63:0] sram_line;

    always_comb sram_line = {sram_mem[{sram_addr[8:1], 1'b1}], sram_mem[{sram_addr[8:1], 1'b0}]};
    assign sram_dq = sram_oe ? sram_line : {64{1'bz}};

    always @(negedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[8:0]] <= sram_dq[31:0];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] exp_rd;
    logic [63:0] exp_rd64;
    logic        exp_err;
    int          last_waddr;
    int          n_cmp;
    int          n_fail;
    localparam logic [63:0] RELEASED = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 4 * DEPTH) && (a % 4 == 0);
    endfunction

    // Issue one request from an IDLE cycle and follow it through DONE.
    // With hold=1 the request lines stay asserted afterwards.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        bit legal;
        bit is_read;
        int wa;
        int n_low;
        legal   = is_legal(a);
        is_read = !w && r;
        wa      = legal ? int'((a - 32'(BASE)) / 4) : 0;
        n_low   = legal ? WAIT + 1 : 1;
        wr_en = w; rd_en = r; address = a; writeData = d;
        for (int i = 0; i < n_low; i++) begin
            sram_oe = legal && is_read && (i == WAIT);
            @(negedge clk);
            check("ready_low", 64'(ready), 64'(0));
            if (i >= 1) check("sram_addr", 64'(sram_addr), 64'(wa));
            if (legal && w && i >= 1) begin
                check("we_n_write", 64'(sram_we_n), (i == 1) ? 64'(0) : 64'(1));
                check("dq_write", sram_dq, {32'h0, d});
            end else begin
                check("we_n_idle", 64'(sram_we_n), 64'(1));
                if (!sram_oe) check("dq_released", sram_dq, RELEASED);
            end
            @(posedge clk); #1;
            if (i == 0 && !hold) begin
                wr_en = 1'b0; rd_en = 1'b0;
                address = $urandom; writeData = $urandom;
            end
        end
        sram_oe = 1'b0;
        exp_err = !legal;
        if (legal) begin
            last_waddr = wa;
            if (w) begin
                ref_mem[wa] = d;
            end else begin
                exp_rd   = ref_mem[wa];
                exp_rd64 = {ref_mem[wa | 1], ref_mem[wa & ~1]};
            end
        end
        @(negedge clk);
        check("ready_done", 64'(ready), 64'(1));
        check("we_n_done", 64'(sram_we_n), 64'(1));
        check("dq_done", sram_dq, RELEASED);
        check("addr_err", 64'(addr_err), 64'(exp_err));
        check("readData", 64'(readData), 64'(exp_rd));
        check("readData64", readData64, exp_rd64);
        check("sram_addr_hold", 64'(sram_addr), 64'(last_waddr));
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [63:0] exp_rd64;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; writeData = 32'h0;
        sram_oe = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        exp_rd = 32'h0; exp_rd64 = 64'h0; exp_err = 1'b0; last_waddr = 0;

        vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0,        64'h0,                     1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF, 64'h00000000_DEADBEEF,     1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF, 64'h00000000_DEADBEEF,     1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd1028, 32'h0,        32'h12345678, 64'h12345678_DEADBEEF,     1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd1020, 32'h0,        32'h12345678, 64'h12345678_DEADBEEF,     1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'd1026, 32'h0,        32'h12345678, 64'h12345678_DEADBEEF,     1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'd3072, 32'h0,        32'h12345678, 64'h12345678_DEADBEEF,     1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h12345678, 64'h12345678_DEADBEEF,     1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd1032, 32'h0,        32'hA5A5A5A5, 64'h00000000_A5A5A5A5,     1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'd3068, 32'h0BADF00D, 32'hA5A5A5A5, 64'h00000000_A5A5A5A5,     1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd3068, 32'h0,        32'h0BADF00D, 64'h0BADF00D_00000000,     1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0,    32'h0BADF00D, 64'h0BADF00D_00000000,     1'b1});

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_we_n", 64'(sram_we_n), 64'(1));
        check("rst_sram_addr", 64'(sram_addr), 64'(0));
        check("rst_dq", sram_dq, RELEASED);
        check("rst_readData", 64'(readData), 64'(0));
        check("rst_readData64", readData64, 64'(0));
        check("rst_addr_err", 64'(addr_err), 64'(0));
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            access(vecs[k].w, vecs[k].r, vecs[k].addr, vecs[k].data, 1'b0);
            check("tbl_readData", 64'(readData), 64'(vecs[k].exp_rd));
            check("tbl_readData64", readData64, vecs[k].exp_rd64);
            check("tbl_addr_err", 64'(addr_err), 64'(vecs[k].exp_err));
        end

        // back-to-back: read held across DONE is served twice
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

        // reset in the third ACCESS cycle of a write; the strobed write survives
        wr_en = 1'b1; address = 32'd1036; writeData = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[3] = 32'hCAFEF00D;
        exp_rd = 32'h0; exp_rd64 = 64'h0; exp_err = 1'b0; last_waddr = 0;
        @(negedge clk);
        check("mid_rst_ready", 64'(ready), 64'(1));
        check("mid_rst_we_n", 64'(sram_we_n), 64'(1));
        check("mid_rst_dq", sram_dq, RELEASED);
        check("mid_rst_readData", 64'(readData), 64'(0));
        check("mid_rst_readData64", readData64, 64'(0));
        check("mid_rst_addr_err", 64'(addr_err), 64'(0));
        check("mid_rst_sram_addr", 64'(sram_addr), 64'(0));
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
        check("strobed_write_kept", 64'(readData), 64'(32'hCAFEF00D));

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic        w;
            logic        r;
            int          kind;
            kind = $urandom_range(0, 11);
            case (kind)
                0:       a = 32'(BASE) - 32'(4 * $urandom_range(1, 8));
                1:       a = 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                2:       a = 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 8));
                3:       a = 32'(BASE + 4 * $urandom_range(DEPTH - 2, DEPTH - 1));
                default: a = 32'(BASE + 4 * $urandom_range(0, 15));
            endcase
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                access(w, r, a, $urandom, 1'b1);
                access(w, r, a, writeData, 1'b0);
            end else begin
                access(w, r, a, $urandom, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
